// File: rtl/ofs_plat_avalon_mem_arb_pkg.sv
// Shared types for the round-robin Avalon-MM bank arbiter: FSM states, read tags
// and the rotating-priority select used to pick the next requester.
package ofs_plat_avalon_mem_arb_pkg;

  localparam int unsigned ARB_MAX_REQ = 8;
  localparam int unsigned ARB_ID_W    = 3;
  localparam int unsigned ARB_BCNT_W  = 7;

  typedef enum logic [1:0] {
    ARB,
    HOLD,
    WR_BURST
  } t_arb_state;

  typedef struct packed {
    logic [ARB_ID_W-1:0]   id;
    logic [ARB_BCNT_W-1:0] burstcount;
  } t_rd_tag;

  typedef struct packed {
    logic                valid;
    logic [ARB_ID_W-1:0] idx;
  } t_rr_pick;

  // First set bit of req at or above ptr, wrapping within the low n bits.
  function automatic t_rr_pick rr_pick(input logic [ARB_MAX_REQ-1:0] req,
                                       input logic [ARB_ID_W-1:0]    ptr,
                                       input int unsigned            n);
    t_rr_pick            p;
    int unsigned         j;
    logic [ARB_ID_W-1:0] k;
    p = '0;
    for (int unsigned i = 0; i < ARB_MAX_REQ; i++) begin
      j = 32'(ptr) + i;
      if (j >= n) j = j - n;
      k = ARB_ID_W'(j);
      if ((i < n) && !p.valid && req[k]) begin
        p.valid = 1'b1;
        p.idx   = k;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/ofs_plat_avalon_mem_arb_tag_fifo.sv
// In-order FIFO of read tags; a pop frees a slot for a push in the same cycle,
// so push while full is accepted only alongside a pop.
module ofs_plat_avalon_mem_arb_tag_fifo
  import ofs_plat_avalon_mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic    clk,
  input  logic    reset_n,
  input  logic    push,
  input  t_rd_tag push_data,
  input  logic    pop,
  output t_rd_tag head,
  output logic    full,
  output logic    empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  t_rd_tag          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ofs_plat_avalon_mem_rr_arbiter.sv
// Round-robin, burst-aware arbiter sharing one Avalon-MM bank among NUM_REQ requesters.
// Define OFS_PLAT_AVMM_ARB_ASSERT_EN to compile simulation protocol checks.
module ofs_plat_avalon_mem_rr_arbiter
  import ofs_plat_avalon_mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned ADDR_WIDTH      = 27,
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned BURST_CNT_WIDTH = 7,
  parameter int unsigned RD_FIFO_DEPTH   = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_REQ-1:0]                req_read,
  input  logic [NUM_REQ-1:0]                req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_address,
  input  logic [NUM_REQ*BURST_CNT_WIDTH-1:0] req_burstcount,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_writedata,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   req_byteenable,
  output logic [NUM_REQ-1:0]                req_waitrequest,
  output logic [DATA_WIDTH-1:0]             req_readdata,
  output logic [NUM_REQ-1:0]                req_readdatavalid,
  output logic                              mem_read,
  output logic                              mem_write,
  output logic [ADDR_WIDTH-1:0]             mem_address,
  output logic [BURST_CNT_WIDTH-1:0]        mem_burstcount,
  output logic [DATA_WIDTH-1:0]             mem_writedata,
  output logic [DATA_WIDTH/8-1:0]           mem_byteenable,
  input  logic                              mem_waitrequest,
  input  logic [DATA_WIDTH-1:0]             mem_readdata,
  input  logic                              mem_readdatavalid
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);
  localparam int unsigned BE_W = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0]      addr_a  [NUM_REQ];
  logic [BURST_CNT_WIDTH-1:0] burst_a [NUM_REQ];
  logic [DATA_WIDTH-1:0]      wdata_a [NUM_REQ];
  logic [BE_W-1:0]            be_a    [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_a[i]  = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign burst_a[i] = req_burstcount[i*BURST_CNT_WIDTH +: BURST_CNT_WIDTH];
    assign wdata_a[i] = req_writedata[i*DATA_WIDTH +: DATA_WIDTH];
    assign be_a[i]    = req_byteenable[i*BE_W +: BE_W];
  end

  t_arb_state                 state, state_nxt;
  logic [ID_W-1:0]            grant, grant_nxt;
  logic [ID_W-1:0]            rr_ptr, rr_ptr_nxt;
  logic [BURST_CNT_WIDTH-1:0] remaining, remaining_nxt;
  logic [ARB_BCNT_W-1:0]      beat_cnt;

  logic            tag_push, tag_pop, tag_full, tag_empty, rd_ok, active, accept;
  t_rd_tag         tag_in, tag_head;
  t_rr_pick        pick;
  logic [NUM_REQ-1:0]         cand;
  logic [ID_W-1:0]            cur, ptr_inc;
  logic [BURST_CNT_WIDTH-1:0] cur_bc;

  // A response beat that retires the head tag frees a slot for a same-cycle read push.
  assign tag_pop = mem_readdatavalid & ~tag_empty &
                   ((beat_cnt + 1'b1) == tag_head.burstcount);
  assign rd_ok   = ~tag_full | tag_pop;
  assign cand    = req_write | (req_read & {NUM_REQ{rd_ok}});
  assign pick    = rr_pick(ARB_MAX_REQ'(cand), ARB_ID_W'(rr_ptr), NUM_REQ);

  always_comb begin
    cur    = grant;
    active = reset_n;
    if (state == ARB) begin
      active = reset_n & pick.valid;
      for (int unsigned i = 0; i < NUM_REQ; i++)
        if (pick.idx == ARB_ID_W'(i)) cur = ID_W'(i);
    end
    cur_bc          = (burst_a[cur] == '0) ? BURST_CNT_WIDTH'(1) : burst_a[cur];
    mem_read        = active & req_read[cur] & rd_ok & (state != WR_BURST);
    mem_write       = active & req_write[cur];
    mem_address     = addr_a[cur];
    mem_burstcount  = cur_bc;
    mem_writedata   = wdata_a[cur];
    mem_byteenable  = be_a[cur];
    req_waitrequest = '1;
    if (active) req_waitrequest[cur] = mem_waitrequest;
  end

  assign accept  = (mem_read | mem_write) & ~mem_waitrequest;
  assign ptr_inc = (cur == ID_W'(NUM_REQ - 1)) ? '0 : cur + 1'b1;

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    rr_ptr_nxt    = rr_ptr;
    remaining_nxt = remaining;
    unique case (state)
      ARB, HOLD: begin
        if (mem_read | mem_write) begin
          grant_nxt = cur;
          if (mem_waitrequest) begin
            state_nxt = HOLD;
          end else if (mem_write && (cur_bc > BURST_CNT_WIDTH'(1))) begin
            state_nxt     = WR_BURST;
            remaining_nxt = cur_bc - 1'b1;
          end else begin
            state_nxt  = ARB;
            rr_ptr_nxt = ptr_inc;
          end
        end else if (state == HOLD) begin
          state_nxt = ARB;
        end
      end
      WR_BURST: begin
        if (accept) begin
          remaining_nxt = remaining - 1'b1;
          if (remaining == BURST_CNT_WIDTH'(1)) begin
            state_nxt  = ARB;
            rr_ptr_nxt = ptr_inc;
          end
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ARB;
      grant     <= '0;
      rr_ptr    <= '0;
      remaining <= '0;
      beat_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      rr_ptr    <= rr_ptr_nxt;
      remaining <= remaining_nxt;
      if (mem_readdatavalid && !tag_empty)
        beat_cnt <= tag_pop ? '0 : beat_cnt + 1'b1;
    end
  end

  assign tag_push          = accept & mem_read;
  assign tag_in.id         = ARB_ID_W'(cur);
  assign tag_in.burstcount = ARB_BCNT_W'(cur_bc);

  ofs_plat_avalon_mem_arb_tag_fifo #(
    .DEPTH(RD_FIFO_DEPTH)
  ) tag_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (tag_push),
    .push_data(tag_in),
    .pop      (tag_pop),
    .head     (tag_head),
    .full     (tag_full),
    .empty    (tag_empty)
  );

  assign req_readdata = mem_readdata;

  always_comb begin
    req_readdatavalid = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++)
      req_readdatavalid[i] = reset_n & mem_readdatavalid & ~tag_empty &
                             (tag_head.id == ARB_ID_W'(i));
  end

`ifdef OFS_PLAT_AVMM_ARB_ASSERT_EN
  logic                       chk_valid;
  logic [ID_W-1:0]            chk_id;
  logic                       chk_rd, chk_wr;
  logic [ADDR_WIDTH-1:0]      chk_addr;
  logic [BURST_CNT_WIDTH-1:0] chk_bc;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      chk_valid <= 1'b0;
    end else begin
      chk_valid <= (mem_read | mem_write) & mem_waitrequest;
      chk_id    <= cur;
      chk_rd    <= req_read[cur];
      chk_wr    <= req_write[cur];
      chk_addr  <= addr_a[cur];
      chk_bc    <= burst_a[cur];
      for (int unsigned i = 0; i < NUM_REQ; i++)
        if (req_read[i] && req_write[i])
          $fatal(1, "avmm arb: simultaneous read and write from requester %0d", i);
      if (chk_valid && ((req_read[chk_id] != chk_rd) || (req_write[chk_id] != chk_wr) ||
                        (addr_a[chk_id] != chk_addr) || (burst_a[chk_id] != chk_bc)))
        $fatal(1, "avmm arb: request changed under waitrequest, requester %0d", chk_id);
      if (mem_readdatavalid && tag_empty)
        $fatal(1, "avmm arb: readdatavalid with empty tag FIFO, requester %0d", cur);
      if ((state == WR_BURST) && req_read[grant])
        $fatal(1, "avmm arb: read during locked write burst, requester %0d", grant);
    end
  end
`endif

endmodule

// File: tb/tb_ofs_plat_avalon_mem_rr_arbiter.sv
// Randomized bench for the RR bank arbiter, checked each cycle against a queue-based
// model of grant order, burst locking, hold-under-wait and read-response steering.
module tb_ofs_plat_avalon_mem_rr_arbiter;

  localparam int NR = 4, AW = 27, DW = 512, BW = 7, DEPTH = 16, BEW = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic [NR-1:0]     req_read, req_write, req_waitrequest, req_readdatavalid;
  logic [NR*AW-1:0]  req_address;
  logic [NR*BW-1:0]  req_burstcount;
  logic [NR*DW-1:0]  req_writedata;
  logic [NR*BEW-1:0] req_byteenable;
  logic [DW-1:0]     req_readdata;
  logic              mem_read, mem_write, mem_waitrequest, mem_readdatavalid;
  logic [AW-1:0]     mem_address;
  logic [BW-1:0]     mem_burstcount;
  logic [DW-1:0]     mem_writedata, mem_readdata;
  logic [BEW-1:0]    mem_byteenable;

  // Requester-side masters
  logic          m_rd [NR];
  logic          m_wr [NR];
  logic [AW-1:0] m_addr [NR];
  logic [BW-1:0] m_bc [NR];
  logic [DW-1:0] m_wd [NR];
  logic [BEW-1:0] m_be [NR];
  int            m_left [NR];
  bit            acc_rd [NR];
  bit            acc_wr [NR];

  for (genvar g = 0; g < NR; g++) begin : g_pack
    assign req_read[g]                 = m_rd[g];
    assign req_write[g]                = m_wr[g];
    assign req_address[g*AW +: AW]     = m_addr[g];
    assign req_burstcount[g*BW +: BW]  = m_bc[g];
    assign req_writedata[g*DW +: DW]   = m_wd[g];
    assign req_byteenable[g*BEW +: BEW] = m_be[g];
  end

  ofs_plat_avalon_mem_rr_arbiter #(
    .NUM_REQ        (NR),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .BURST_CNT_WIDTH(BW),
    .RD_FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req_read         (req_read),
    .req_write        (req_write),
    .req_address      (req_address),
    .req_burstcount   (req_burstcount),
    .req_writedata    (req_writedata),
    .req_byteenable   (req_byteenable),
    .req_waitrequest  (req_waitrequest),
    .req_readdata     (req_readdata),
    .req_readdatavalid(req_readdatavalid),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_address      (mem_address),
    .mem_burstcount   (mem_burstcount),
    .mem_writedata    (mem_writedata),
    .mem_byteenable   (mem_byteenable),
    .mem_waitrequest  (mem_waitrequest),
    .mem_readdata     (mem_readdata),
    .mem_readdatavalid(mem_readdatavalid)
  );

  // Reference model: outstanding read bursts in issue order, plus arbitration bookkeeping
  typedef struct {
    int id;
    int bc;
  } tag_t;

  tag_t tq[$];
  int   mcnt, mptr, mlock, mrem, mhold, bank_beats;
  int   gcount [NR];
  int   first_grant;
  int   pass_cnt = 0, chk_cnt = 0;

  function automatic int eff(input logic [BW-1:0] b);
    return (b == '0) ? 1 : int'(b);
  endfunction

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_check();
    int            g;
    bit            blk, pop_now, er, ew;
    logic [NR-1:0] exp_wait, exp_rdv;
    pop_now = mem_readdatavalid && (tq.size() > 0) && (mcnt + 1 == tq[0].bc);
    blk     = (tq.size() == DEPTH) && !pop_now;
    g = -1;
    if (mlock >= 0) g = mlock;
    else if (mhold >= 0) g = mhold;
    else
      for (int k = 0; k < NR; k++) begin
        int c;
        c = (mptr + k) % NR;
        if (g < 0 && (m_wr[c] || (m_rd[c] && !blk))) g = c;
      end
    er = (g >= 0) && m_rd[g] && !blk && (mlock < 0);
    ew = (g >= 0) && m_wr[g];
    exp_wait = '1;
    if (g >= 0) exp_wait[g] = mem_waitrequest;
    exp_rdv = '0;
    if (mem_readdatavalid && tq.size() > 0) exp_rdv[tq[0].id] = 1'b1;

    check_eq("mem_read", DW'(mem_read), DW'(er));
    check_eq("mem_write", DW'(mem_write), DW'(ew));
    check_eq("req_waitrequest", DW'(req_waitrequest), DW'(exp_wait));
    check_eq("req_readdatavalid", DW'(req_readdatavalid), DW'(exp_rdv));
    check_eq("req_readdata", req_readdata, mem_readdata);
    if (er || ew) begin
      check_eq("mem_address", DW'(mem_address), DW'(m_addr[g]));
      check_eq("mem_burstcount", DW'(mem_burstcount), DW'(eff(m_bc[g])));
    end
    if (ew) begin
      check_eq("mem_writedata", mem_writedata, m_wd[g]);
      check_eq("mem_byteenable", DW'(mem_byteenable), DW'(m_be[g]));
    end

    if (mem_read && !mem_waitrequest)
      for (int k = 0; k < NR; k++)
        if (!req_waitrequest[k]) begin
          gcount[k]++;
          if (first_grant < 0) first_grant = k;
        end

    // Responses retire against the queue as it stood before this cycle's push
    if (mem_readdatavalid && tq.size() > 0) begin
      bank_beats--;
      mcnt++;
      if (mcnt == tq[0].bc) begin
        void'(tq.pop_front());
        mcnt = 0;
      end
    end

    if (er || ew) begin
      if (mem_waitrequest) mhold = g;
      else begin
        mhold = -1;
        if (er) begin
          tq.push_back('{g, eff(m_bc[g])});
          bank_beats += eff(m_bc[g]);
          acc_rd[g] = 1'b1;
          mptr = (g + 1) % NR;
        end
        if (ew) begin
          acc_wr[g] = 1'b1;
          if (mlock >= 0) begin
            mrem--;
            if (mrem == 0) begin
              mlock = -1;
              mptr  = (g + 1) % NR;
            end
          end else if (eff(m_bc[g]) > 1) begin
            mlock = g;
            mrem  = eff(m_bc[g]) - 1;
          end else mptr = (g + 1) % NR;
        end
      end
    end
  endtask

  // One clock: drive just after posedge, check and update the model at negedge
  task automatic cycle(input int p_new, input int p_wr, input int p_wait, input int p_rdv,
                       input int max_bc);
    for (int i = 0; i < NR; i++) begin
      if (acc_rd[i]) m_rd[i] = 1'b0;
      if (acc_wr[i]) begin
        m_left[i]--;
        if (m_left[i] == 0) m_wr[i] = 1'b0;
        else m_wd[i] = {16{$urandom}};
      end
      acc_rd[i] = 1'b0;
      acc_wr[i] = 1'b0;
      if (!m_rd[i] && !m_wr[i] && int'($urandom_range(99)) < p_new) begin
        m_bc[i]   = BW'($urandom_range(max_bc, 0));
        m_addr[i] = AW'($urandom);
        m_wd[i]   = {16{$urandom}};
        m_be[i]   = {2{$urandom}};
        if (int'($urandom_range(99)) < p_wr) begin
          m_wr[i]   = 1'b1;
          m_left[i] = eff(m_bc[i]);
        end else m_rd[i] = 1'b1;
      end
    end
    mem_waitrequest   = int'($urandom_range(99)) < p_wait;
    mem_readdatavalid = (bank_beats > 0) ? (int'($urandom_range(99)) < p_rdv)
                                         : ((p_rdv > 0) && ($urandom_range(199) == 0));
    mem_readdata      = {16{$urandom}};
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n           = 1'b0;
    mem_waitrequest   = 1'b0;
    mem_readdatavalid = 1'b1;
    mem_readdata      = '0;
    for (int i = 0; i < NR; i++) begin
      m_rd[i] = 1'b1; m_wr[i] = 1'b0; m_addr[i] = AW'(i * 16); m_bc[i] = BW'(1);
      m_wd[i] = '0; m_be[i] = '1; m_left[i] = 0; acc_rd[i] = 1'b0; acc_wr[i] = 1'b0;
      gcount[i] = 0;
    end
    mcnt = 0; mptr = 0; mlock = -1; mrem = 0; mhold = -1; bank_beats = 0; first_grant = -1;

    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("reset_mem_read", DW'(mem_read), DW'(1'b0));
      check_eq("reset_mem_write", DW'(mem_write), DW'(1'b0));
      check_eq("reset_waitrequest", DW'(req_waitrequest), DW'(4'b1111));
      check_eq("reset_readdatavalid", DW'(req_readdatavalid), DW'(4'b0000));
    end
    @(posedge clk);
    #1;
    reset_n           = 1'b1;
    mem_readdatavalid = 1'b0;

    // Continuous single-beat reads from everyone, no backpressure
    repeat (400) cycle(100, 0, 0, 100, 1);
    check_eq("first_grant", DW'(first_grant), DW'(0));
    for (int k = 0; k < NR; k++) check_eq("fair_share", DW'(gcount[k]), DW'(100));

    repeat (1500) cycle(40, 50, 30, 60, 4);   // mixed traffic and bursts
    repeat (150)  cycle(60, 30, 10, 0, 2);    // no responses: tag FIFO fills, writes continue
    repeat (300)  cycle(60, 30, 10, 50, 2);   // drain while full: pop and push together
    repeat (500)  cycle(50, 50, 80, 60, 4);   // heavy backpressure
    repeat (200)  cycle(0, 0, 0, 100, 1);     // quiesce

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
